// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_bit1_adder.sv
// Single-bit full adder used as the only arithmetic element of serial_adder.
module bit1_adder (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Co,
  output logic So
);

  assign So = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, through a single bit1_adder.
// S/Co are only updated on entry to DONE; busy/done are registered decodes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
  logic             carry_q, carry_d, co_q, co_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_so, fa_co;

  bit1_adder u_fa (
    .A  (a_q[0]),
    .B  (b_q[0]),
    .Ci (carry_q),
    .Co (fa_co),
    .So (fa_so)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with state_q.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Ci;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_so, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d  = {fa_so, sum_q[WIDTH-1:1]};
          co_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign Co   = co_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4) against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Ci = 1'b0;
  logic [W-1:0] S;
  logic         Co;
  logic         busy;
  logic         done;

  int unsigned  vectors = 0;
  int unsigned  errors = 0;
  logic [W-1:0] last_s = '0;
  logic         last_co = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Ci    (Ci),
    .S     (S),
    .Co    (Co),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full addition from IDLE, with random noise on the inputs while running.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int unsigned  total;
    logic [W-1:0] es;
    logic         eco;
    total = int'(a) + int'(b) + int'(ci);
    es    = W'(total % (1 << W));
    eco   = (total >= (1 << W));
    A = a; B = b; Ci = ci; start = 1'b1;
    tick();
    for (int i = 0; i < int'(W); i++) begin
      A = W'($urandom); B = W'($urandom); Ci = 1'($urandom); start = 1'($urandom);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_flags a=%h b=%h ci=%b cyc%0d: busy=%b done=%b, required busy=1 done=0",
                 a, b, ci, i, busy, done);
      end
      vectors++;
      if ({Co, S} !== {last_co, last_s}) begin
        errors++;
        $display("FAIL run_hold a=%h b=%h ci=%b cyc%0d: Co,S=%b,%h, required %b,%h",
                 a, b, ci, i, Co, S, last_co, last_s);
      end
      tick();
    end
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_flags a=%h b=%h ci=%b: busy=%b done=%b, required busy=0 done=1",
               a, b, ci, busy, done);
    end
    vectors++;
    if ({Co, S} !== {eco, es}) begin
      errors++;
      $display("FAIL result a=%h b=%h ci=%b: Co,S=%b,%h, required %b,%h", a, b, ci, Co, S, eco, es);
    end
    last_s = es; last_co = eco;
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || {Co, S} !== {eco, es}) begin
      errors++;
      $display("FAIL idle_after a=%h b=%h ci=%b: busy=%b done=%b Co,S=%b,%h, required 0 0 %b,%h",
               a, b, ci, busy, done, Co, S, eco, es);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; A = W'($urandom); B = W'($urandom); Ci = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({Co, S, busy, done} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: Co=%b S=%h busy=%b done=%b, required all 0", i, Co, S, busy, done);
      end
      tick();
    end
    last_s = '0; last_co = 1'b0;
    rst_n = 1'b1;
    run_add(4'd6, 4'd11, 1'b1);
  endtask

  task automatic test_basic();
    run_add(4'd5, 4'd3, 1'b0);
  endtask

  task automatic test_wrap();
    run_add(4'hF, 4'h1, 1'b0);
    run_add(4'hF, 4'hF, 1'b1);
    run_add(4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_start_ignored();
    int unsigned dones;
    dones = 0;
    A = 4'd2; B = 4'd2; Ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 4'd7; B = 4'd7; Ci = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; A = '0; B = '0; Ci = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) begin
        dones++;
        vectors++;
        if ({Co, S} !== {1'b0, 4'd4}) begin
          errors++;
          $display("FAIL ignore_result: Co,S=%b,%h, required 0,4", Co, S);
        end
      end
      tick();
    end
    vectors++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_done_count: %0d done pulses, required 1", dones);
    end
    vectors++;
    if ({Co, S} !== {1'b0, 4'd4} || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_hold: busy=%b Co,S=%b,%h, required 0 0,4", busy, Co, S);
    end
    last_s = 4'd4; last_co = 1'b0;
    run_add(4'd10, 4'd9, 1'b0);
  endtask

  task automatic test_reset_mid();
    A = 4'd9; B = 4'd9; Ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({Co, S, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_async: Co=%b S=%h busy=%b done=%b, required all 0", Co, S, busy, done);
    end
    last_s = '0; last_co = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(W) + 2; i++) begin
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || {Co, S} !== '0) begin
        errors++;
        $display("FAIL reset_abort cyc%0d: busy=%b done=%b Co,S=%b,%h, required 0 0 0,0", i, busy, done, Co, S);
      end
      tick();
    end
    run_add(4'd1, 4'd1, 1'b1);
  endtask

  task automatic test_exhaustive();
    logic [8:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      run_add(v[3:0], v[7:4], v[8]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_add(W'($urandom), W'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_exhaustive();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
